// File: rtl/apb_cnt_ctrl.sv
// apb_cnt_ctrl
// APB-programmable controller for a modulo-N counter. Software starts, stops,
// resumes and clears the counter. A prescaler divides the clock into count ticks.
// The counter runs one-shot or auto-reload up to LIMIT. It raises a one-cycle
// cout pulse on each terminal tick and keeps a sticky DONE flag that drives irq.
//
// Parameters
//   CNT_WIDTH       width of count value and LIMIT register
//   APB_ADDR_WIDTH  APB byte-address width (bits above [4:0] must be 0 for a hit)
//   APB_DATA_WIDTH  APB data width (>= CNT_WIDTH, >= 8)
//
// Ports
//   clk, rstn                      clock, synchronous active-low reset
//   psel, penable, pwrite          APB control
//   paddr, pwdata                  APB address / write data
//   prdata, pready, pslverr        APB read data, ready (tied 1), error on unmapped
//   cnt                            current count
//   cout                           one-cycle terminal pulse
//   irq                            interrupt level (DONE & IRQ_EN, registered)
//
// Register map
//   0x00 CTRL    W b0 START, b1 STOP, b2 CLR (strobes, read 0); RW b3 MODE, b4 IRQ_EN
//   0x04 LIMIT   RW [CNT_WIDTH-1:0]
//   0x08 PRESC   RW [7:0]
//   0x0C STATUS  b0 DONE (sticky, W1C), b[2:1] state (RO)
//   0x10 COUNT   RO cnt
//   0x14 WRAPS   RO saturating terminal-tick count, only with APB_CNT_CTRL_WRAP_CNT_EN
//
// Build option: define APB_CNT_CTRL_WRAP_CNT_EN to add the WRAPS register.
// Without it, 0x14 is unmapped.

module apb_cnt_ctrl #(
  parameter int CNT_WIDTH      = 4,
  parameter int APB_ADDR_WIDTH = 8,
  parameter int APB_DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [APB_ADDR_WIDTH-1:0] paddr,
  input  logic [APB_DATA_WIDTH-1:0] pwdata,
  output logic [APB_DATA_WIDTH-1:0] prdata,
  output logic                      pready,
  output logic                      pslverr,
  output logic [CNT_WIDTH-1:0]      cnt,
  output logic                      cout,
  output logic                      irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  state_t               state, state_nx;
  logic [CNT_WIDTH-1:0] limit_q;
  logic [CNT_WIDTH-1:0] cnt_nx;
  logic [7:0]           presc_q;
  logic [7:0]           pcnt, pcnt_nx;
  logic                 mode_q, irq_en_q, done_q, done_nx;

  // ---------------------------------------------------------------------------
  // APB decode
  // ---------------------------------------------------------------------------
  logic       acc, wr_acc, rd_acc;
  logic [4:0] addr_lo;
  logic       addr_hi_ok;
  logic       hit_ctrl, hit_limit, hit_presc, hit_status, hit_count, hit_wraps;
  logic       mapped;

  assign acc        = psel & penable;
  assign wr_acc     = acc & pwrite;
  assign rd_acc     = acc & ~pwrite;
  assign addr_lo    = paddr[4:0];
  assign addr_hi_ok = (paddr[APB_ADDR_WIDTH-1:5] == '0);

  always_comb begin
    hit_ctrl   = addr_hi_ok && (addr_lo == 5'h00);
    hit_limit  = addr_hi_ok && (addr_lo == 5'h04);
    hit_presc  = addr_hi_ok && (addr_lo == 5'h08);
    hit_status = addr_hi_ok && (addr_lo == 5'h0C);
    hit_count  = addr_hi_ok && (addr_lo == 5'h10);
`ifdef APB_CNT_CTRL_WRAP_CNT_EN
    hit_wraps  = addr_hi_ok && (addr_lo == 5'h14);
`else
    hit_wraps  = 1'b0;
`endif
    mapped = hit_ctrl | hit_limit | hit_presc | hit_status | hit_count | hit_wraps;
  end

  logic ctrl_wr, limit_wr, presc_wr, status_wr;

  assign ctrl_wr   = wr_acc & hit_ctrl;
  assign limit_wr  = wr_acc & hit_limit;
  assign presc_wr  = wr_acc & hit_presc;
  assign status_wr = wr_acc & hit_status;

  assign pready  = 1'b1;
  assign pslverr = rstn & acc & ~mapped;

  // ---------------------------------------------------------------------------
  // Command resolution: CLR > STOP > START. A higher-priority strobe masks the
  // lower ones even when it is itself ignored in the current state.
  // ---------------------------------------------------------------------------
  logic do_clr, do_stop, do_start, fresh_start;
  logic tick, eff_tick, term;

  assign do_clr      = ctrl_wr & pwdata[2];
  assign do_stop     = ctrl_wr & ~pwdata[2] & pwdata[1] & (state == ST_RUN);
  assign do_start    = ctrl_wr & ~pwdata[2] & ~pwdata[1] & pwdata[0] & (state != ST_RUN);
  // START from IDLE or DONE restarts from zero; START from HOLD resumes.
  assign fresh_start = do_start & (state != ST_HOLD);

  assign tick     = (state == ST_RUN) && (pcnt == presc_q);
  // An acting strobe owns this cycle; a coincident tick is dropped.
  assign eff_tick = tick & ~(do_clr | do_stop | do_start);
  assign term     = eff_tick && (cnt >= limit_q);

  // ---------------------------------------------------------------------------
  // FSM and datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pcnt_nx  = pcnt;

    if (do_clr) begin
      state_nx = ST_IDLE;
      cnt_nx   = '0;
      pcnt_nx  = '0;
    end else if (do_stop) begin
      state_nx = ST_HOLD;
    end else if (do_start) begin
      state_nx = ST_RUN;
      if (fresh_start) begin
        cnt_nx  = '0;
        pcnt_nx = '0;
      end
    end else begin
      case (state)
        ST_RUN: begin
          if (tick) begin
            pcnt_nx = '0;
            if (cnt >= limit_q) begin
              if (mode_q) cnt_nx   = '0;
              else        state_nx = ST_DONE;
            end else begin
              cnt_nx = cnt + CNT_WIDTH'(1);
            end
          end else begin
            pcnt_nx = pcnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Set beats a simultaneous write-1-to-clear.
  assign done_nx = term | (done_q & ~(status_wr & pwdata[0]));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      pcnt     <= '0;
      cout     <= 1'b0;
      irq      <= 1'b0;
      limit_q  <= CNT_WIDTH'(9);
      presc_q  <= '0;
      mode_q   <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      pcnt   <= pcnt_nx;
      cout   <= term;
      irq    <= done_q & irq_en_q;
      done_q <= done_nx;
      if (ctrl_wr) begin
        mode_q   <= pwdata[3];
        irq_en_q <= pwdata[4];
      end
      if (limit_wr) limit_q <= pwdata[CNT_WIDTH-1:0];
      if (presc_wr) presc_q <= pwdata[7:0];
    end
  end

`ifdef APB_CNT_CTRL_WRAP_CNT_EN
  logic [7:0] wraps_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wraps_q <= '0;
    end else if (do_clr || fresh_start) begin
      wraps_q <= '0;
    end else if (term && (wraps_q != 8'hFF)) begin
      wraps_q <= wraps_q + 8'd1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [APB_DATA_WIDTH-1:0] rdata;

  always_comb begin
    rdata = '0;
    if (hit_ctrl) begin
      rdata[3] = mode_q;
      rdata[4] = irq_en_q;
    end
    if (hit_limit)  rdata[CNT_WIDTH-1:0] = limit_q;
    if (hit_presc)  rdata[7:0]           = presc_q;
    if (hit_status) begin
      rdata[0]   = done_q;
      rdata[2:1] = state;
    end
    if (hit_count)  rdata[CNT_WIDTH-1:0] = cnt;
`ifdef APB_CNT_CTRL_WRAP_CNT_EN
    if (hit_wraps)  rdata[7:0]           = wraps_q;
`endif
    prdata = (rd_acc && rstn) ? rdata : '0;
  end

endmodule

// File: tb/tb_apb_cnt_ctrl.sv
// tb_apb_cnt_ctrl
// Self-checking bench for apb_cnt_ctrl. Directed scenarios plus randomized APB
// traffic, checked every cycle against a behavioural model of the controller.
`timescale 1ns/1ps

module tb_apb_cnt_ctrl;

  localparam int CW = 4;
  localparam int AW = 8;
  localparam int DW = 8;
`ifdef APB_CNT_CTRL_WRAP_CNT_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_HOLD = 2;
  localparam int S_DONE = 3;

  logic          clk = 1'b0;
  logic          rstn, psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic          pready, pslverr;
  logic [CW-1:0] cnt;
  logic          cout, irq;

  always #5 clk = ~clk;

  apb_cnt_ctrl #(
    .CNT_WIDTH      (CW),
    .APB_ADDR_WIDTH (AW),
    .APB_DATA_WIDTH (DW)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .cnt     (cnt),
    .cout    (cout),
    .irq     (irq)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  logic        last_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int          m_state;
  int unsigned m_cnt, m_pre, m_limit, m_presc, m_wraps;
  bit          m_mode, m_ien, m_done, m_cout, m_irq;

  function automatic bit mapped(input int unsigned a);
    return (a == 0) || (a == 4) || (a == 8) || (a == 12) || (a == 16) || (WRAP && a == 20);
  endfunction

  function automatic int unsigned exp_rd(input int unsigned a);
    case (a)
      0:  return (int'(m_ien) << 4) | (int'(m_mode) << 3);
      4:  return m_limit;
      8:  return m_presc;
      12: return (m_state << 1) | int'(m_done);
      16: return m_cnt;
      20: return WRAP ? m_wraps : 0;
      default: return 0;
    endcase
  endfunction

  // Applies one rising edge to the model using the bus values present at it.
  task automatic model_edge();
    int unsigned a, d, n_cnt, n_pre, n_wraps;
    int          n_state;
    bit          wr, s_start, s_stop, s_clr, term, n_irq, w1c;
    if (!rstn) begin
      m_state = S_IDLE; m_cnt = 0; m_pre = 0; m_limit = 9; m_presc = 0;
      m_mode = 0; m_ien = 0; m_done = 0; m_cout = 0; m_irq = 0; m_wraps = 0;
      return;
    end
    a  = paddr;
    d  = pwdata;
    wr = psel && penable && pwrite && mapped(a);
    s_start = wr && a == 0 && ((d >> 0) & 1) != 0;
    s_stop  = wr && a == 0 && ((d >> 1) & 1) != 0;
    s_clr   = wr && a == 0 && ((d >> 2) & 1) != 0;
    n_irq   = m_done && m_ien;
    n_state = m_state; n_cnt = m_cnt; n_pre = m_pre; n_wraps = m_wraps;
    term    = 0;
    if (s_clr) begin
      n_state = S_IDLE; n_cnt = 0; n_pre = 0; n_wraps = 0;
    end else if (s_stop) begin
      if (m_state == S_RUN) n_state = S_HOLD;
    end else if (s_start && m_state != S_RUN) begin
      n_state = S_RUN;
      if (m_state != S_HOLD) begin
        n_cnt = 0; n_pre = 0; n_wraps = 0;
      end
    end else if (m_state == S_RUN) begin
      if (m_pre == m_presc) begin
        n_pre = 0;
        if (m_cnt >= m_limit) begin
          term = 1;
          if (m_mode) n_cnt = 0;
          else        n_state = S_DONE;
        end else begin
          n_cnt = m_cnt + 1;
        end
      end else begin
        n_pre = m_pre + 1;
      end
    end
    if (term && n_wraps < 255) n_wraps++;
    w1c    = wr && a == 12 && (d & 1) != 0;
    m_done = term || (m_done && !w1c);
    if (wr && a == 0) begin
      m_mode = ((d >> 3) & 1) != 0;
      m_ien  = ((d >> 4) & 1) != 0;
    end
    if (wr && a == 4) m_limit = d & 15;
    if (wr && a == 8) m_presc = d & 255;
    m_state = n_state; m_cnt = n_cnt; m_pre = n_pre; m_wraps = n_wraps;
    m_cout  = term;
    m_irq   = n_irq;
  endtask

  // ---------------------------------------------------------------------------
  // One clock: check combinational APB outputs, take the edge, check registers.
  // ---------------------------------------------------------------------------
  task automatic step();
    int unsigned a;
    a = paddr;
    #1;
    chk("pready", 32'(pready), 32'd1);
    chk("pslverr", 32'(pslverr), 32'(rstn && psel && penable && !mapped(a)));
    chk("prdata", 32'(prdata), (rstn && psel && penable && !pwrite) ? exp_rd(a) : 32'd0);
    @(posedge clk);
    model_edge();
    #1;
    chk("cnt", 32'(cnt), m_cnt);
    chk("cout", 32'(cout), 32'(m_cout));
    chk("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic apb_wr(input int unsigned a, input int unsigned d);
    psel = 1; penable = 0; pwrite = 1; paddr = AW'(a); pwdata = DW'(d);
    step();
    penable = 1;
    #1 last_err = pslverr;
    step();
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic apb_rd(input int unsigned a, output int unsigned d);
    psel = 1; penable = 0; pwrite = 0; paddr = AW'(a);
    step();
    penable = 1;
    #1;
    d = prdata;
    last_err = pslverr;
    step();
    psel = 0; penable = 0;
  endtask

  task automatic do_reset();
    rstn = 0;
    step();
    step();
    rstn = 1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int unsigned d, v, ncout, a, op;
    int          first;
    int unsigned alist[9] = '{0, 4, 8, 12, 16, 20, 28, 1, 36};
    int unsigned slist[7] = '{0, 1, 1, 2, 4, 7, 1};

    rstn = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    last_err = 0;
    do_reset();

    // Reset values
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    apb_rd(4, d);  chk("rst_limit", d, 9);
    apb_rd(12, d); chk("rst_status", d, 0);

    // Auto-reload decade count
    apb_wr(0, 32'h09);
    first = -1; ncout = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (cout) begin
        ncout++;
        if (first < 0) first = k;
      end
    end
    chk("decade_cout_lat", 32'(first), 32'd10);
    chk("decade_cout_n", ncout, 3);
    apb_rd(12, d); chk("decade_done", d & 1, 1);

    // One-shot with prescale and interrupt
    apb_wr(0, 32'h04);
    apb_wr(12, 1);
    apb_wr(4, 3);
    apb_wr(8, 2);
    apb_wr(0, 32'h11);
    idle(20);
    chk("oneshot_cnt", 32'(cnt), 32'd3);
    apb_rd(12, d); chk("oneshot_status", d, 7);
    chk("oneshot_irq", 32'(irq), 32'd1);
    apb_wr(12, 1);
    idle(2);
    chk("w1c_irq", 32'(irq), 32'd0);

    // Pause / resume / clear
    apb_wr(4, 9);
    apb_wr(8, 1);
    apb_wr(0, 32'h01);
    for (int i = 0; i < 200 && m_cnt != 5; i++) step();
    chk("pause_reach5", 32'(cnt), 32'd5);
    apb_wr(0, 32'h02);
    idle(20);
    chk("pause_hold_cnt", 32'(cnt), 32'd5);
    apb_rd(12, d); chk("pause_state", (d >> 1) & 3, 2);
    apb_wr(0, 32'h01);
    idle(1);
    chk("resume_cnt", 32'(cnt), 32'd6);
    idle(3);
    apb_wr(0, 32'h04);
    apb_rd(12, d); chk("clr_state", (d >> 1) & 3, 0);
    chk("clr_cnt", 32'(cnt), 32'd0);

    // LIMIT=0: terminal on every tick
    apb_wr(4, 0);
    apb_wr(8, 0);
    apb_wr(0, 32'h09);
    ncout = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (cout) ncout++;
    end
    chk("lim0_cout_n", ncout, 6);

    // Lower LIMIT below cnt mid-run
    apb_wr(0, 32'h04);
    apb_wr(4, 9);
    apb_wr(8, 3);
    apb_wr(0, 32'h01);
    for (int i = 0; i < 200 && m_cnt != 7; i++) step();
    chk("lower_reach7", 32'(cnt), 32'd7);
    apb_wr(4, 2);
    idle(3);
    apb_rd(12, d); chk("lower_state", (d >> 1) & 3, 3);
    chk("lower_cnt", 32'(cnt), 32'd7);

    // All strobes together -> IDLE
    apb_wr(0, 32'h01);
    idle(2);
    apb_wr(0, 32'h07);
    apb_rd(12, d); chk("all_strobe_state", (d >> 1) & 3, 0);

    // Unmapped access
    apb_rd(4, v);
    apb_wr(32'h1C, 5);
    chk("unmapped_err", 32'(last_err), 32'd1);
    apb_rd(4, d); chk("unmapped_noeffect", d, v);

    // Wrap counter
    apb_wr(0, 32'h04);
    apb_wr(4, 0);
    apb_wr(8, 0);
    apb_wr(0, 32'h09);
    idle(310);
    apb_rd(20, d);
`ifdef APB_CNT_CTRL_WRAP_CNT_EN
    chk("wraps_sat", d, 255);
    chk("wraps_err", 32'(last_err), 32'd0);
    apb_wr(0, 32'h04);
    apb_rd(20, d); chk("wraps_clr", d, 0);
`else
    chk("wraps_off_err", 32'(last_err), 32'd1);
    chk("wraps_off_rd", d, 0);
`endif

    // Randomized traffic
    apb_wr(0, 32'h04);
    apb_wr(4, 3);
    for (int it = 0; it < 2500; it++) begin
      op = $urandom % 40;
      if (op < 22) begin
        a = alist[$urandom % 9];
        case (a)
          0:  d = slist[$urandom % 7] | (($urandom % 4) << 3);
          4:  d = ($urandom % 4 == 0) ? $urandom % 16 : $urandom_range(0, 5);
          8:  d = $urandom_range(0, 3);
          12: d = $urandom % 2;
          default: d = $urandom % 256;
        endcase
        apb_wr(a, d);
      end else if (op < 32) begin
        apb_rd(alist[$urandom % 9], d);
      end else if (op < 39) begin
        idle($urandom_range(1, 6));
      end else begin
        do_reset();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
